// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 burst memory slave with independent read/write FSMs
// Backing store is a 64-bit word array; errors are decided once per burst at the address handshake.
module axi4_burst_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_AW    = 16,
    parameter int          ID_W      = 4
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESETN,
    input  logic [ID_W-1:0] S_AXI_AWID,
    input  logic [31:0]     S_AXI_AWADDR,
    input  logic [7:0]      S_AXI_AWLEN,
    input  logic [2:0]      S_AXI_AWSIZE,
    input  logic [1:0]      S_AXI_AWBURST,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [63:0]     S_AXI_WDATA,
    input  logic [7:0]      S_AXI_WSTRB,
    input  logic            S_AXI_WLAST,
    input  logic            S_AXI_WVALID,
    output logic            S_AXI_WREADY,
    output logic [ID_W-1:0] S_AXI_BID,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [ID_W-1:0] S_AXI_ARID,
    input  logic [31:0]     S_AXI_ARADDR,
    input  logic [7:0]      S_AXI_ARLEN,
    input  logic [2:0]      S_AXI_ARSIZE,
    input  logic [1:0]      S_AXI_ARBURST,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    output logic [ID_W-1:0] S_AXI_RID,
    output logic [63:0]     S_AXI_RDATA,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY
);
    localparam int         MEM_WORDS   = 2 ** MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    logic [63:0] mem_q [MEM_WORDS];

    function automatic logic [1:0] decode_err(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [2:0] size);
        logic [32:0] top;
        top = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 3);
        if ({1'b0, addr} < {1'b0, BASE_ADDR} || {1'b0, addr} >= top) decode_err = RESP_DECERR;
        else if (burst[1] || size > 3'd3)                              decode_err = RESP_SLVERR;
        else                                                           decode_err = RESP_OKAY;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [2:0] size);
        next_addr = (burst == 2'b00) ? addr : addr + (32'd1 << size);
    endfunction

    wstate_e         wstate_q, wstate_d;
    logic [ID_W-1:0] wid_q, wid_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [8:0]      wcnt_q, wcnt_d;
    logic [2:0]      wsize_q, wsize_d;
    logic [1:0]      wburst_q, wburst_d;
    logic [1:0]      werr_q, werr_d;
    logic            wlast_bad_q, wlast_bad_d;
    logic            mem_we;

    rstate_e         rstate_q, rstate_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     raddr_q, raddr_d;
    logic [8:0]      rcnt_q, rcnt_d;
    logic [2:0]      rsize_q, rsize_d;
    logic [1:0]      rburst_q, rburst_d;
    logic [1:0]      rerr_q, rerr_d;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wstate_q    <= W_IDLE;
            wid_q       <= '0;
            waddr_q     <= '0;
            wcnt_q      <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            werr_q      <= RESP_OKAY;
            wlast_bad_q <= 1'b0;
            rstate_q    <= R_IDLE;
            rid_q       <= '0;
            raddr_q     <= '0;
            rcnt_q      <= '0;
            rsize_q     <= '0;
            rburst_q    <= '0;
            rerr_q      <= RESP_OKAY;
        end else begin
            wstate_q    <= wstate_d;
            wid_q       <= wid_d;
            waddr_q     <= waddr_d;
            wcnt_q      <= wcnt_d;
            wsize_q     <= wsize_d;
            wburst_q    <= wburst_d;
            werr_q      <= werr_d;
            wlast_bad_q <= wlast_bad_d;
            rstate_q    <= rstate_d;
            rid_q       <= rid_d;
            raddr_q     <= raddr_d;
            rcnt_q      <= rcnt_d;
            rsize_q     <= rsize_d;
            rburst_q    <= rburst_d;
            rerr_q      <= rerr_d;
        end
    end

    // The beat counter, not WLAST, terminates the burst; WLAST only flags a protocol error.
    always_comb begin
        wstate_d      = wstate_q;
        wid_d         = wid_q;
        waddr_d       = waddr_q;
        wcnt_d        = wcnt_q;
        wsize_d       = wsize_q;
        wburst_d      = wburst_q;
        werr_d        = werr_q;
        wlast_bad_d   = wlast_bad_q;
        mem_we        = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) begin
                    wid_d       = S_AXI_AWID;
                    waddr_d     = S_AXI_AWADDR;
                    wcnt_d      = {1'b0, S_AXI_AWLEN} + 9'd1;
                    wsize_d     = S_AXI_AWSIZE;
                    wburst_d    = S_AXI_AWBURST;
                    werr_d      = decode_err(S_AXI_AWADDR, S_AXI_AWBURST, S_AXI_AWSIZE);
                    wlast_bad_d = 1'b0;
                    wstate_d    = W_DATA;
                end
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    mem_we  = (werr_q == RESP_OKAY);
                    waddr_d = next_addr(waddr_q, wburst_q, wsize_q);
                    wcnt_d  = wcnt_q - 9'd1;
                    if (S_AXI_WLAST != (wcnt_q == 9'd1)) wlast_bad_d = 1'b1;
                    if (wcnt_q == 9'd1) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign S_AXI_BID   = wid_q;
    assign S_AXI_BRESP = (werr_q != RESP_OKAY) ? werr_q : (wlast_bad_q ? RESP_SLVERR : RESP_OKAY);

    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we && S_AXI_ARESETN) begin
            for (int i = 0; i < 8; i++) begin
                if (S_AXI_WSTRB[i]) mem_q[waddr_q[MEM_AW+2:3]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        rstate_d      = rstate_q;
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        rcnt_d        = rcnt_q;
        rsize_d       = rsize_q;
        rburst_d      = rburst_q;
        rerr_d        = rerr_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) begin
                    rid_d    = S_AXI_ARID;
                    raddr_d  = S_AXI_ARADDR;
                    rcnt_d   = {1'b0, S_AXI_ARLEN} + 9'd1;
                    rsize_d  = S_AXI_ARSIZE;
                    rburst_d = S_AXI_ARBURST;
                    rerr_d   = decode_err(S_AXI_ARADDR, S_AXI_ARBURST, S_AXI_ARSIZE);
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    raddr_d = next_addr(raddr_q, rburst_q, rsize_q);
                    rcnt_d  = rcnt_q - 9'd1;
                    if (rcnt_q == 9'd1) rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Combinational read of the registered address gives read-first behaviour against a same-cycle write.
    assign S_AXI_RID   = rid_q;
    assign S_AXI_RRESP = rerr_q;
    assign S_AXI_RLAST = S_AXI_RVALID && (rcnt_q == 9'd1);
    assign S_AXI_RDATA = (S_AXI_RVALID && rerr_q == RESP_OKAY) ? mem_q[raddr_q[MEM_AW+2:3]] : 64'd0;

endmodule
